btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz).
REQ-002 Parameter RPT_DELAY, default 25000000, cycles from accepted press to first auto-repeat.
REQ-003 Parameter RPT_PERIOD, default 5000000, cycles between subsequent auto-repeats.
REQ-004 Parameter CNT_W, default 25, debounce/repeat counter width; SHALL hold max(DEB_CYCLES, RPT_DELAY, RPT_PERIOD).
REQ-005 i_Clk  input  1  system clock; all state on rising edge.
REQ-006 i_Rst  input  1  reset, asynchronous, active-high.
REQ-007 i_Btn  input  1  raw push button, active-low (0 = pressed), asynchronous to i_Clk, bouncing.
REQ-008 o_Push  output  1  debounced button level, same polarity as i_Btn; drives the BCD counter's i_Push directly.
REQ-009 o_Pulse  output  1  single-cycle high strobe per accepted press and per auto-repeat.
REQ-010 o_Held  output  1  high while FSM is in PRESSED or REL_CHK.

Function
REQ-011 i_Btn SHALL pass through a 2-flop synchronizer before any other use; synchronized value = btn_s.
REQ-012 FSM states SHALL be IDLE, PRESS_CHK, PRESSED, REL_CHK.
REQ-013 IDLE: btn_s=0 -> PRESS_CHK, counter cleared; else stay; o_Push=1.
REQ-014 PRESS_CHK: btn_s=1 -> IDLE (bounce rejected, no pulse); counter reaching DEB_CYCLES-1 with btn_s=0 -> PRESSED, o_Push=0, o_Pulse=1 for exactly that one cycle.
REQ-015 PRESSED: btn_s=1 -> REL_CHK, counter cleared; o_Push stays 0.
REQ-016 REL_CHK: btn_s=0 -> PRESSED with no new pulse and repeat timer restarted; counter reaching DEB_CYCLES-1 with btn_s=1 -> IDLE, o_Push=1.
REQ-017 Press latency: o_Push falls and o_Pulse fires exactly 2+DEB_CYCLES cycles after the first rising edge sampling i_Btn=0 when i_Btn stays low.
REQ-018 Release latency: o_Push rises exactly 2+DEB_CYCLES cycles after the first edge sampling i_Btn=1 when i_Btn stays high; release SHALL never pulse o_Pulse.
REQ-019 Any bounce shorter than DEB_CYCLES synchronized cycles SHALL produce no change on o_Push, o_Pulse or o_Held.
REQ-020 Counters SHALL saturate, never wrap; DEB_CYCLES=1 SHALL accept after a single stable sample.

Reset
REQ-021 i_Rst high SHALL immediately force: synchronizer flops 1, state IDLE, all counters 0, o_Push=1, o_Pulse=0, o_Held=0.
REQ-022 Reset mid-operation SHALL discard in-progress qualification; a button still held after reset release SHALL be re-qualified and pulse once after 2+DEB_CYCLES cycles.

Configuration
REQ-023 Macro BTN_AUTOREPEAT_EN defined: in PRESSED, a repeat event SHALL occur RPT_DELAY cycles after entry, then every RPT_PERIOD cycles; each event SHALL raise o_Pulse for one cycle and drive o_Push to 1 for exactly that cycle, so the downstream counter sees a fresh 1->0 edge.
REQ-024 Macro BTN_AUTOREPEAT_EN undefined: repeat timer and logic SHALL be absent; exactly one pulse per press regardless of hold time.

Structure
REQ-025 Package btn_pkg SHALL hold the FSM state typedef (4 states, 2-bit encoding) and default parameter constants.
REQ-026 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameterizable, here 1); FSM, counters and repeat timer stay in btn_debounce.

Verification (DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8)
REQ-027 Clean press: i_Btn 1->0, held 30 cycles -> o_Push=0 and single o_Pulse exactly 6 cycles after first low sample; o_Held=1 thereafter.
REQ-028 Press bounce: i_Btn low 3, high 1, low 2, high 1, then low steady -> no activity until 4 consecutive btn_s lows; exactly one o_Pulse.
REQ-029 Release bounce: from PRESSED, i_Btn high 2, low 1, high steady -> zero o_Pulse; o_Push=1 exactly 6 cycles after final rise.
REQ-030 Auto-repeat: hold 50 cycles after accepted press -> macro defined: repeats at +20, +28, +36, +44 (4 pulses, o_Push=1 one cycle each); macro undefined: 0 repeats.
REQ-031 Reset mid-PRESS_CHK with i_Btn held low -> outputs at reset values immediately; one o_Pulse 6 cycles after i_Rst deasserts.
REQ-032 Integration: o_Push into BCD counter i_Push, 12 debounced presses with bounce, up mode -> counter 0->9->0->1->2, carry exactly once.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Build with BTN_AUTOREPEAT_EN defined to enable auto-repeat on long presses.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    localparam int DEF_DEB_CYCLES = 500000;
    localparam int DEF_RPT_DELAY  = 25000000;
    localparam int DEF_RPT_PERIOD = 5000000;
    localparam int DEF_CNT_W      = 25;

    // The button counts as held until the release has been qualified.
    function automatic logic is_held(input btn_state_t s);
        return (s == PRESSED) || (s == REL_CHK);
    endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RST_VAL sets the value both flops take while i_Rst is high.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Active-low push-button debouncer: synchronizer, 4-state qualify FSM, press strobe.
// Defining BTN_AUTOREPEAT_EN adds a repeat timer that re-strobes while held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Btn,
    output logic o_Push,
    output logic o_Pulse,
    output logic o_Held
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam longint CNT_CAP = (longint'(1) << CNT_W) - 1;

    if (DEB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1 ||
        longint'(DEB_CYCLES) > CNT_CAP || longint'(RPT_DELAY) > CNT_CAP ||
        longint'(RPT_PERIOD) > CNT_CAP) begin : g_bad_cfg
        $error("btn_debounce: timing parameters must be >= 1 and fit in CNT_W bits");
    end

    logic             w_btn_s;
    btn_state_t       r_state;
    btn_state_t       w_state_next;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] w_deb_cnt_next;
    logic [CNT_W-1:0] w_deb_inc;
    logic             r_Push;
    logic             r_Pulse;
    logic             w_push_next;
    logic             w_pulse_next;
    logic             w_rpt_evt;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_Btn),
        .o_Q   (w_btn_s)
    );

    assign w_deb_inc = (r_deb_cnt == '1) ? r_deb_cnt : r_deb_cnt + 1'b1;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);

    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    logic             w_rpt_restart;
    logic [CNT_W-1:0] w_rpt_limit;

    // Any entry into PRESSED, including a rejected release bounce, restarts the delay.
    assign w_rpt_restart = (w_state_next == PRESSED) && (r_state != PRESSED);
    assign w_rpt_limit   = r_rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
    assign w_rpt_evt     = (r_state == PRESSED) && !w_btn_s && (r_rpt_cnt >= w_rpt_limit);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_restart) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_evt) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else if (r_state == PRESSED && r_rpt_cnt != '1) begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end
`else
    assign w_rpt_evt = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_deb_cnt_next = w_deb_inc;
        w_pulse_next   = 1'b0;
        case (r_state)
            IDLE: begin
                w_deb_cnt_next = '0;
                if (!w_btn_s) begin
                    w_state_next = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (w_btn_s) begin
                    w_state_next   = IDLE;
                    w_deb_cnt_next = '0;
                end else if (r_deb_cnt >= DEB_LAST) begin
                    w_state_next   = PRESSED;
                    w_deb_cnt_next = '0;
                    w_pulse_next   = 1'b1;
                end
            end
            PRESSED: begin
                w_deb_cnt_next = '0;
                if (w_btn_s) begin
                    w_state_next = REL_CHK;
                end else begin
                    w_pulse_next = w_rpt_evt;
                end
            end
            REL_CHK: begin
                if (!w_btn_s) begin
                    w_state_next   = PRESSED;
                    w_deb_cnt_next = '0;
                end else if (r_deb_cnt >= DEB_LAST) begin
                    w_state_next   = IDLE;
                    w_deb_cnt_next = '0;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_deb_cnt_next = '0;
            end
        endcase
        // A repeat lifts o_Push for one cycle so downstream logic sees a new falling edge.
        w_push_next = !is_held(w_state_next) || w_rpt_evt;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_Push    <= 1'b1;
            r_Pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_deb_cnt <= w_deb_cnt_next;
            r_Push    <= w_push_next;
            r_Pulse   <= w_pulse_next;
        end
    end

    assign o_Push  = r_Push;
    assign o_Pulse = r_Pulse;
    assign o_Held  = is_held(r_state);

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8.
// Expected repeat counts follow BTN_AUTOREPEAT_EN; a small BCD model counts o_Push falls.
module tb_btn_debounce;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_ON = 1;
`else
    localparam int RPT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic push;
    logic pulse;
    logic held;

    btn_debounce #(
        .DEB_CYCLES (DEB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP),
        .CNT_W      (8)
    ) dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Btn   (btn),
        .o_Push  (push),
        .o_Pulse (pulse),
        .o_Held  (held)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   pulse_cnt, first_pulse, pulse_sum, base;
    int   fall_cnt, first_fall, last_rise, push_hi, held_hi;
    int   bcd_digit, bcd_carry;
    int   c0, c1, c2, c3;
    logic prev_push = 1'b1;

    task automatic clr();
        pulse_cnt   = 0;
        first_pulse = -1;
        pulse_sum   = 0;
        base        = cyc;
        fall_cnt    = 0;
        first_fall  = -1;
        last_rise   = -1;
        push_hi     = 0;
        held_hi     = 0;
        bcd_digit   = 0;
        bcd_carry   = 0;
    endtask

    // Advance n clocks, sampling outputs 1 ns after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            if (pulse) begin
                if (pulse_cnt == 0) first_pulse = cyc;
                pulse_cnt++;
                pulse_sum += cyc - base;
            end
            if (push) push_hi++;
            if (held) held_hi++;
            if (prev_push && !push) begin
                if (fall_cnt == 0) first_fall = cyc;
                fall_cnt++;
                if (bcd_digit == 9) begin
                    bcd_digit = 0;
                    bcd_carry++;
                end else begin
                    bcd_digit++;
                end
            end
            if (!prev_push && push) last_rise = cyc;
            prev_push = push;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        clr();
        tick(3);
        chk("rst_push", int'(push), 1);
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_held", int'(held), 0);
        rst = 1'b0;
        tick(2);
        $display("reset: push=%0b pulse=%0b held=%0b", push, pulse, held);

        // Clean press held 30 cycles
        clr();
        btn = 1'b0;
        c0 = cyc + 1;
        tick(30);
        chk("press_pulses", pulse_cnt, 1 + RPT_ON);
        chk("press_pulse_cyc", first_pulse, c0 + 6);
        chk("press_fall_cyc", first_fall, c0 + 6);
        chk("press_held", int'(held), 1);
        chk("press_push", int'(push), 0);
        $display("clean press: first pulse at +%0d, pulses=%0d", first_pulse - c0, pulse_cnt);

        // Release bounce: high 2, low 1, high steady
        clr();
        btn = 1'b1; tick(2);
        btn = 1'b0; tick(1);
        btn = 1'b1;
        c1 = cyc + 1;
        tick(12);
        chk("rel_pulses", pulse_cnt, 0);
        chk("rel_rise_cyc", last_rise, c1 + 6);
        chk("rel_held", int'(held), 0);
        $display("release bounce: rise at +%0d, pulses=%0d", last_rise - c1, pulse_cnt);

        // Press bounce: low 3, high 1, low 2, high 1, then low steady
        clr();
        btn = 1'b0; tick(3);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(2);
        btn = 1'b1; tick(1);
        chk("bnc_pulses_early", pulse_cnt, 0);
        chk("bnc_held_cycles", held_hi, 0);
        chk("bnc_falls_early", fall_cnt, 0);
        btn = 1'b0;
        c2 = cyc + 1;
        tick(18);
        chk("bnc_pulses", pulse_cnt, 1);
        chk("bnc_pulse_cyc", first_pulse, c2 + 6);
        btn = 1'b1;
        tick(10);
        chk("bnc_release_push", int'(push), 1);
        $display("press bounce: pulse at +%0d after steady low, pulses=%0d", first_pulse - c2, pulse_cnt);

        // Long hold: repeats at +20, +28, +36, +44 when enabled
        clr();
        btn = 1'b0;
        tick(7);
        chk("rpt_accept", pulse_cnt, 1);
        clr();
        tick(50);
        chk("rpt_count", pulse_cnt, 4 * RPT_ON);
        chk("rpt_offsets", pulse_sum, 128 * RPT_ON);
        chk("rpt_push_cycles", push_hi, 4 * RPT_ON);
        btn = 1'b1;
        tick(10);
        chk("rpt_release_held", int'(held), 0);
        $display("auto-repeat: repeats=%0d offset_sum=%0d", pulse_cnt, pulse_sum);

        // Reset in the middle of press qualification
        btn = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        chk("midrst_push", int'(push), 1);
        chk("midrst_pulse", int'(pulse), 0);
        chk("midrst_held", int'(held), 0);
        tick(2);
        rst = 1'b0;
        clr();
        c3 = cyc + 1;
        tick(12);
        chk("midrst_pulses", pulse_cnt, 1);
        chk("midrst_pulse_cyc", first_pulse, c3 + 6);
        $display("mid-qualify reset: pulse at +%0d after release", first_pulse - c3);

        // Integration: 12 bouncy presses into a BCD up counter
        btn = 1'b1;
        tick(10);
        clr();
        for (int k = 0; k < 12; k++) begin
            btn = 1'b0; tick(2);
            btn = 1'b1; tick(1);
            btn = 1'b0; tick(12);
            btn = 1'b1; tick(1);
            btn = 1'b0; tick(1);
            btn = 1'b1; tick(10);
        end
        chk("bcd_presses", fall_cnt, 12);
        chk("bcd_digit", bcd_digit, 2);
        chk("bcd_carry", bcd_carry, 1);
        $display("bcd: presses=%0d digit=%0d carries=%0d", fall_cnt, bcd_digit, bcd_carry);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
